core_seq_ctrl: RTL and testbench
================================

Name: core_seq_ctrl

Overview:
Instruction sequencer for one attention core. It produces the 17-bit core instruction word every cycle and steps one run through six phases: Q-memory fill, K-memory fill, kernel load into the MAC array, execute, OFIFO drain into PSUM memory, and PSUM readout to the normalizer. A host or testbench supplies Q/K rows through a valid/ready port, and the sequencer drives the core's `inst` input directly.

Parameters:
col, 8, MAC array columns; number of K rows loaded as kernel
nq, 8, Q rows (tokens) per run; legal range 1..16
kload_gap, 2, idle cycles between kernel load and execute
norm_gap, 9, cycles from one pmem_rd pulse to the next; covers the normalizer's 8-lane serialisation plus 1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
start  input  1  one-cycle pulse; begins a run when idle
host_valid  input  1  current mem_in row is valid
host_ready  output  1  sequencer accepts a row this cycle
fifo_valid  input  1  OFIFO holds a complete output row
inst  output  17  core instruction word (field map below)
busy  output  1  high from the accepted start until done
done  output  1  one-cycle pulse at the end of a run
phase  output  3  current FSM state encoding

Behaviour:
- inst field map:
  - [16] ofifo_rd; [15:12] qkmem_add; [11:8] pmem_add
  - [7] execute; [6] kernel load, which also selects kmem to the MAC input
  - [5] qmem_rd; [4] qmem_wr; [3] kmem_rd; [2] kmem_wr; [1] pmem_rd; [0] pmem_wr
- All outputs are registered.
- Reset values: inst=0, busy=0, done=0, host_ready=0, phase=IDLE(0); all counters are 0.
- FSM states and encodings: IDLE 0, QWR 1, KWR 2, KLOAD 3, EXEC 4, DRAIN 5, NORM 6, FIN 7.
- IDLE:
  - start=1 -> QWR, busy=1.
  - start while busy is ignored.
- QWR:
  - host_ready=1.
  - Each cycle with host_valid=1: qmem_wr=1 with qkmem_add=cnt, then cnt++.
  - After nq rows: cnt=0 -> KWR.
  - host_valid=0 stalls the phase with no write.
- KWR: same handshake using kmem_wr, for col rows -> KLOAD.
- KLOAD:
  - col cycles of kmem_rd=1 and inst[6]=1, with addr 0..col-1.
  - Then kload_gap cycles with inst=0 -> EXEC.
- EXEC:
  - nq cycles of qmem_rd=1 and inst[7]=1, with addr 0..nq-1, back-to-back.
  - Then -> DRAIN.
- DRAIN:
  - When fifo_valid=1 and a read is not already in flight: ofifo_rd=1 at cycle t.
  - At cycle t+1: pmem_wr=1 with pmem_add=row index.
  - At most one read per 2 cycles.
  - After nq writes -> NORM.
  - fifo_valid low waits indefinitely.
- NORM:
  - For row r=0..nq-1: pmem_rd=1 for one cycle with pmem_add=r, then inst=0 for norm_gap-1 cycles.
  - After the last gap -> FIN.
- FIN: done=1 for one cycle, busy=0 -> IDLE.
- Address counters are 4 bits. nq=16 wraps to 0 exactly at the phase exit and is never reused within the phase.
- Only the bits listed for a phase may be 1. All other inst bits are 0, including addresses outside active cycles.
- Reset mid-run: next cycle is IDLE with all outputs at reset values. No partial done.
- start coinciding with reset: reset wins.

Optional Feature:
CORE_SEQ_PERF_EN: when defined, adds two outputs.
- run_cycles[15:0]: cycles from the accepted start to done, latched on done. It saturates at 16'hFFFF.
- stall_cycles[15:0]: cycles spent waiting on host_valid=0 or fifo_valid=0 during the run.
- Both reset to 0.
When undefined, these ports and their counters are absent and all other behaviour is identical.

Test Plan:
1. Reset, then start with host_valid held 1 (defaults): 8 qmem_wr at addrs 0..7, then 8 kmem_wr, 8 kload cycles, 2 idle cycles, 8 exec cycles. inst[6] high only during KLOAD.
2. Toggle host_valid every other cycle in QWR: exactly 8 qmem_wr pulses, addrs contiguous, no write in cycles where host_valid=0.
3. DRAIN with fifo_valid asserted only on cycles 0, 5, 6 and 20 onward: each ofifo_rd is followed 1 cycle later by pmem_wr with pmem_add=0..7; never two ofifo_rd in consecutive cycles.
4. NORM phase: pmem_rd pulses exactly 9 cycles apart, pmem_add 0..7. done pulses once, 9 cycles after the last pmem_rd; busy falls the same cycle.
5. Assert reset during EXEC, then release: inst=0, phase=0, no done. A new start completes a full run normally.
6. With CORE_SEQ_PERF_EN and 3 host stall cycles injected: stall_cycles=3, and run_cycles equals the start-to-done count.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: instruction sequencer for one attention core. It steps one run
//   through Q fill, K fill, kernel load, execute, OFIFO drain and PSUM readout.
//   Every output is registered, so each inst word appears one cycle after the
//   inputs that caused it were sampled.
// Ports: clk, reset (sync, active-high), start (run request pulse),
//   host_valid/host_ready (Q/K row handshake), fifo_valid (OFIFO row ready),
//   inst[16:0] (core instruction word), busy, done (end-of-run pulse),
//   phase[2:0] (FSM state).
// Optional: define CORE_SEQ_PERF_EN to add run_cycles[15:0] and stall_cycles[15:0].
module core_seq_ctrl #(
  parameter int col       = 8,
  parameter int nq        = 8,
  parameter int kload_gap = 2,
  parameter int norm_gap  = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        fifo_valid,
  output logic [16:0] inst,
  output logic        busy,
  output logic        done,
  output logic [2:0]  phase
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [15:0] run_cycles,
  output logic [15:0] stall_cycles
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] QWR   = 3'd1;
  localparam logic [2:0] KWR   = 3'd2;
  localparam logic [2:0] KLOAD = 3'd3;
  localparam logic [2:0] EXEC  = 3'd4;
  localparam logic [2:0] DRAIN = 3'd5;
  localparam logic [2:0] NORM  = 3'd6;
  localparam logic [2:0] FIN   = 3'd7;

  localparam logic [3:0] NQ_LAST  = 4'(nq - 1);
  localparam logic [3:0] COL_LAST = 4'(col - 1);
  localparam logic [5:0] KL_END   = 6'(col + kload_gap - 1);
  localparam logic [5:0] NG_END   = 6'(norm_gap - 1);

  logic [2:0]  phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;     // row / address counter
  logic [5:0]  step_q, step_d;   // cycle counter inside KLOAD and NORM
  logic        rd_q, rd_d;       // an OFIFO read is in flight (its pmem_wr is next)
  logic [16:0] inst_q, inst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rdy_q, rdy_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    rd_d    = rd_q;
    inst_d  = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (phase_q)
      IDLE: begin
        if (start) begin
          phase_d = QWR;
          busy_d  = 1'b1;
          cnt_d   = '0;
          step_d  = '0;
          rd_d    = 1'b0;
        end
      end
      QWR: begin
        if (host_valid) begin
          inst_d[4]     = 1'b1;
          inst_d[15:12] = cnt_q;
          cnt_d         = cnt_q + 4'd1;
          if (cnt_q == NQ_LAST) begin
            cnt_d   = '0;
            phase_d = KWR;
          end
        end
      end
      KWR: begin
        if (host_valid) begin
          inst_d[2]     = 1'b1;
          inst_d[15:12] = cnt_q;
          cnt_d         = cnt_q + 4'd1;
          if (cnt_q == COL_LAST) begin
            cnt_d   = '0;
            phase_d = KLOAD;
          end
        end
      end
      KLOAD: begin
        // First col steps stream kmem into the array, the rest are idle gap.
        if (step_q < 6'(col)) begin
          inst_d[6]     = 1'b1;
          inst_d[3]     = 1'b1;
          inst_d[15:12] = step_q[3:0];
        end
        if (step_q == KL_END) begin
          step_d  = '0;
          phase_d = EXEC;
        end else begin
          step_d = step_q + 6'd1;
        end
      end
      EXEC: begin
        inst_d[7]     = 1'b1;
        inst_d[5]     = 1'b1;
        inst_d[15:12] = cnt_q;
        cnt_d         = cnt_q + 4'd1;
        if (cnt_q == NQ_LAST) begin
          cnt_d   = '0;
          phase_d = DRAIN;
        end
      end
      DRAIN: begin
        // fifo_valid is ignored while a read is in flight: it may not yet
        // reflect the pop, so reads are spaced at least two cycles apart.
        if (rd_q) begin
          inst_d[0]    = 1'b1;
          inst_d[11:8] = cnt_q;
          rd_d         = 1'b0;
          cnt_d        = cnt_q + 4'd1;
          if (cnt_q == NQ_LAST) begin
            cnt_d   = '0;
            step_d  = '0;
            phase_d = NORM;
          end
        end else if (fifo_valid) begin
          inst_d[16] = 1'b1;
          rd_d       = 1'b1;
        end
      end
      NORM: begin
        if (step_q == 6'd0) begin
          inst_d[1]    = 1'b1;
          inst_d[11:8] = cnt_q;
        end
        if (step_q == NG_END) begin
          step_d = '0;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == NQ_LAST) begin
            cnt_d   = '0;
            phase_d = FIN;
          end
        end else begin
          step_d = step_q + 6'd1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        phase_d = IDLE;
      end
      default: phase_d = IDLE;
    endcase
    rdy_d = (phase_d == QWR) || (phase_d == KWR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      rd_q    <= 1'b0;
      inst_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rd_q    <= rd_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign inst       = inst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign phase      = phase_q;
  assign host_ready = rdy_q;

`ifdef CORE_SEQ_PERF_EN
  logic [15:0] run_cnt_q, run_cycles_q, stall_q;
  logic        stall_now;

  // A stall is a cycle the run could not advance for lack of input data.
  assign stall_now = (((phase_q == QWR) || (phase_q == KWR)) && !host_valid) ||
                     ((phase_q == DRAIN) && !rd_q && !fifo_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q    <= '0;
      run_cycles_q <= '0;
      stall_q      <= '0;
    end else if ((phase_q == IDLE) && start) begin
      run_cnt_q <= '0;
      stall_q   <= '0;
    end else if (phase_q != IDLE) begin
      if (run_cnt_q != 16'hFFFF) run_cnt_q <= run_cnt_q + 16'd1;
      if (stall_now && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      // FIN is the last busy cycle; latch the count including it.
      if (phase_q == FIN)
        run_cycles_q <= (run_cnt_q == 16'hFFFF) ? 16'hFFFF : run_cnt_q + 16'd1;
    end
  end

  assign run_cycles   = run_cycles_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

  localparam int NQ   = 8;
  localparam int COL  = 8;
  localparam int KGAP = 2;
  localparam int NGAP = 9;

  logic        clk = 1'b0;
  logic        reset, start, hv, fv;
  logic        host_ready_o, busy_o, done_o;
  logic [16:0] inst_o;
  logic [2:0]  phase_o;
`ifdef CORE_SEQ_PERF_EN
  logic [15:0] run_cycles_o, stall_cycles_o;
`endif

  core_seq_ctrl #(.col(COL), .nq(NQ), .kload_gap(KGAP), .norm_gap(NGAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .host_valid (hv),
    .host_ready (host_ready_o),
    .fifo_valid (fv),
    .inst       (inst_o),
    .busy       (busy_o),
    .done       (done_o),
    .phase      (phase_o)
`ifdef CORE_SEQ_PERF_EN
    ,
    .run_cycles   (run_cycles_o),
    .stall_cycles (stall_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] w;
    int          gap;   // zero-inst cycles required before this word, -1 = any
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  int          zeros = 0;
  logic [16:0] prev_inst = '0;
  logic [16:0] last_nz = '0;
  logic        hs_prev = 1'b0;
  logic        fv_prev = 1'b0;
  logic        busy_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [16:0] w, input int gap);
    exp_t e;
    e.w   = w;
    e.gap = gap;
    sbq.push_back(e);
  endtask

  // Full nonzero inst stream of one run with default parameters.
  task automatic push_run();
    for (int i = 0; i < NQ; i++)  push((17'(1) << 4) | (17'(i) << 12), -1);
    for (int i = 0; i < COL; i++) push((17'(1) << 2) | (17'(i) << 12), -1);
    for (int i = 0; i < COL; i++) push(17'h00048 | (17'(i) << 12), 0);
    for (int i = 0; i < NQ; i++)  push(17'h000A0 | (17'(i) << 12), (i == 0) ? KGAP : 0);
    for (int r = 0; r < NQ; r++) begin
      push(17'(1) << 16, -1);
      push(17'h00001 | (17'(r) << 8), 0);
    end
    for (int r = 0; r < NQ; r++)  push(17'h00002 | (17'(r) << 8), (r == 0) ? 0 : NGAP - 1);
  endtask

  // Output monitor: pops the scoreboard on every nonzero inst word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_inst = '0;
        zeros     = 0;
        hs_prev   = 1'b0;
        fv_prev   = 1'b0;
        busy_prev = 1'b0;
      end else begin
        if (hs_prev || inst_o[4] || inst_o[2])
          check("wr_matches_handshake", {31'd0, inst_o[4] | inst_o[2]}, {31'd0, hs_prev});
        if (inst_o[16]) begin
          check("ofifo_back_to_back", {31'd0, prev_inst[16]}, 32'd0);
          check("ofifo_needs_fifo_valid", {31'd0, fv_prev}, 32'd1);
        end
        if (prev_inst[16] || inst_o[0])
          check("pmem_wr_after_ofifo_rd", {31'd0, inst_o[0]}, {31'd0, prev_inst[16]});
        if (inst_o != '0) begin
          if (sbq.size() == 0) begin
            check("unexpected_inst", {15'd0, inst_o}, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("inst_word", {15'd0, inst_o}, {15'd0, e.w});
            if (e.gap >= 0) check("inst_gap", zeros, e.gap);
          end
          zeros   = 0;
          last_nz = inst_o;
        end else begin
          zeros++;
        end
        if (done_o) begin
          n_done++;
          check("done_after_last_pmem_rd", zeros, NGAP);
          check("done_last_word", {15'd0, last_nz}, {15'd0, 17'h00002 | (17'(NQ - 1) << 8)});
          check("done_sb_drained", sbq.size(), 0);
          check("busy_low_at_done", {31'd0, busy_o}, 32'd0);
          check("busy_high_before_done", {31'd0, busy_prev}, 32'd1);
        end
        hs_prev   = host_ready_o & hv;
        fv_prev   = fv;
        busy_prev = busy_o;
        prev_inst = inst_o;
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_inst"}, {15'd0, inst_o}, 32'd0);
    check({tag, "_phase"}, {29'd0, phase_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_host_ready"}, {31'd0, host_ready_o}, 32'd0);
  endtask

  // mode 0: inputs always valid, extra start mid-run
  // mode 1: host_valid toggles, sparse fifo_valid in DRAIN
  // mode 2: reset during EXEC
  // mode 3: exactly three host stall cycles in QWR
  task automatic run(input int mode);
    int busy_n = 0;
    int dcnt   = 0;
    int qcyc   = 0;
    bit seen   = 1'b0;
    bit kick   = 1'b0;
    push_run();
    start = 1'b1;
    hv    = (mode != 1);
    fv    = (mode != 1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      if (busy_o) busy_n++;
      if (done_o) begin
        seen = 1'b1;
      end else begin
        case (mode)
          0: begin
            hv = 1'b1;
            fv = 1'b1;
            if (phase_o == 3'd2 && !kick) begin
              start = 1'b1;
              kick  = 1'b1;
            end
          end
          1: begin
            hv = ~hv;
            if (phase_o == 3'd5) begin
              fv = (dcnt == 0 || dcnt == 5 || dcnt == 6 || dcnt >= 20);
              dcnt++;
            end else begin
              fv = 1'b0;
            end
          end
          2: begin
            if (phase_o == 3'd4) begin
              reset = 1'b1;
              @(posedge clk); #1;
              check_idle("abort");
              reset = 1'b0;
              sbq.delete();
              for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                check("abort_no_done", {31'd0, done_o}, 32'd0);
              end
              check("abort_stays_idle", {29'd0, phase_o}, 32'd0);
              return;
            end
          end
          default: begin
            fv = 1'b1;
            hv = !(phase_o == 3'd1 && qcyc >= 2 && qcyc <= 4);
            if (phase_o == 3'd1) qcyc++;
          end
        endcase
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check("run_reached_done", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    check("idle_after_done", {29'd0, phase_o}, 32'd0);
`ifdef CORE_SEQ_PERF_EN
    if (mode == 3) begin
      check("stall_cycles", {16'd0, stall_cycles_o}, 32'd3);
      check("run_cycles", {16'd0, run_cycles_o}, busy_n);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hv    = 1'b0;
    fv    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
`ifdef CORE_SEQ_PERF_EN
    check("reset_run_cycles", {16'd0, run_cycles_o}, 32'd0);
    check("reset_stall_cycles", {16'd0, stall_cycles_o}, 32'd0);
`endif
    // start coinciding with reset must be dropped
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_idle("start_during_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset_release", {29'd0, phase_o}, 32'd0);

    run(0);
    run(1);
    run(2);
    run(3);
    check("done_pulse_count", n_done, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
